// File: rtl/bus_dma_master.sv
// Bus initiator: block copy (RD/WR, 2 cycles/word) or constant fill (1 cycle/word, `DMA_FILL_EN); START->DONE is 2*LEN+1 or LEN+1 cycles.
// LOCK=0 freezes all state and bus outputs; ABORT ends the transfer after the in-flight word.
module bus_dma_master #(
  parameter int ABITS  = 16,
  parameter int DBITS  = 16,
  parameter int SABITS = 1,
  parameter int LBITS  = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             LOCK,
  input  logic             START,
  input  logic [ABITS-1:0] SRC,
  input  logic [ABITS-1:0] DST,
  input  logic [LBITS-1:0] LEN,
  input  logic             FILL,
  input  logic             ABORT,
  input  logic             INTACK,
  output logic             BUSY,
  output logic             DONE,
  output logic             INTR,
  output logic [ABITS-1:0] ABUS,
  output logic             RE,
  output logic             WE,
  output logic [DBITS-1:0] WBUS,
  input  logic [DBITS-1:0] RBUS
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  localparam logic [ABITS-1:0] STEP = ABITS'(1 << SABITS);

  state_t           state, state_n;
  logic [ABITS-1:0] src, dst;
  logic [LBITS-1:0] count;
  logic [DBITS-1:0] data;
  logic             fill_q, abort_q, intr_q;
  logic             fill_start;

`ifdef DMA_FILL_EN
  assign fill_start = FILL;
`else
  logic unused_fill;
  assign unused_fill = FILL;
  assign fill_start  = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ABUS    = '0;
    RE      = 1'b0;
    WE      = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          if (LEN == '0)      state_n = FIN;
          else if (fill_start) state_n = WR;
          else                 state_n = RD;
        end
      end
      RD: begin
        ABUS    = src;
        RE      = 1'b1;
        BUSY    = 1'b1;
        state_n = WR;
      end
      WR: begin
        ABUS = dst;
        WE   = 1'b1;
        BUSY = 1'b1;
        // abort_q carries an ABORT seen during this word's read phase
        if (count == LBITS'(1) || ABORT || abort_q) state_n = FIN;
        else if (fill_q)                            state_n = WR;
        else                                        state_n = RD;
      end
      FIN: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign WBUS = data;
  assign INTR = intr_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      src     <= '0;
      dst     <= '0;
      count   <= '0;
      data    <= '0;
      fill_q  <= 1'b0;
      abort_q <= 1'b0;
      intr_q  <= 1'b0;
    end else if (LOCK) begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (START) begin
            src     <= SRC;
            dst     <= DST;
            count   <= LEN;
            fill_q  <= fill_start;
            abort_q <= 1'b0;
            if (fill_start) data <= DBITS'(SRC);
          end
        end
        RD: begin
          data <= RBUS;
          src  <= src + STEP;
          if (ABORT) abort_q <= 1'b1;
        end
        WR: begin
          dst   <= dst + STEP;
          count <= count - LBITS'(1);
        end
        default: ;
      endcase
      // a completion in the same cycle as INTACK keeps the flag set
      if (state == FIN) intr_q <= 1'b1;
      else if (INTACK)  intr_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed table-driven bench for bus_dma_master with a word-addressed memory responder.
module tb_bus_dma_master;

  logic        CLK = 1'b0;
  logic        RSTN, LOCK, START, FILL, ABORT, INTACK;
  logic [15:0] SRC, DST, LEN;
  logic        BUSY, DONE, INTR, RE, WE;
  logic [15:0] ABUS, WBUS, RBUS;

  bus_dma_master dut (
    .CLK(CLK), .RSTN(RSTN), .LOCK(LOCK), .START(START), .SRC(SRC), .DST(DST),
    .LEN(LEN), .FILL(FILL), .ABORT(ABORT), .INTACK(INTACK), .BUSY(BUSY),
    .DONE(DONE), .INTR(INTR), .ABUS(ABUS), .RE(RE), .WE(WE), .WBUS(WBUS),
    .RBUS(RBUS)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [0:32767];
  logic [15:0] rd_q[$];
  logic [15:0] wr_a[$];
  logic [15:0] wr_d[$];
  int          overlap = 0;
  int          npass = 0;
  int          ntotal = 0;

  assign RBUS = RE ? mem[ABUS[15:1]] : 16'h0000;

  always @(posedge CLK) begin
    if (RSTN && LOCK) begin
      if (RE && WE) overlap++;
      if (RE) rd_q.push_back(ABUS);
      if (WE) begin
        wr_a.push_back(ABUS);
        wr_d.push_back(WBUS);
        mem[ABUS[15:1]] = WBUS;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] src, dst, len;
    logic        fill;
    int          abort_word;
    bit          restart;
    bit          intack_held;
    int          stall_at;
    int          exp_nrd, exp_nwr, exp_lat;
    logic [15:0] exp_rd0, exp_wr_a, exp_wr_d, chk_a, chk_d;
  } vec_t;

  task automatic run_xfer(input string tag, input vec_t v);
    int   lat;
    logic hold_ok;
    lat = -1;
    hold_ok = 1'b1;
    @(negedge CLK);
    rd_q.delete(); wr_a.delete(); wr_d.delete();
    START = 1'b1; SRC = v.src; DST = v.dst; LEN = v.len; FILL = v.fill;
    INTACK = v.intack_held;
    for (int k = 1; k <= 200; k++) begin
      @(negedge CLK);
      START = 1'b0; ABORT = 1'b0; LOCK = 1'b1;
      SRC = v.src; DST = v.dst; LEN = v.len;
      if (DONE) begin
        lat = k;
        break;
      end
      if (v.restart && k == 2) begin
        START = 1'b1; SRC = 16'h0500; DST = 16'h0C00; LEN = 16'd7;
      end
      if (v.stall_at > 0 && k >= v.stall_at && k < v.stall_at + 3) LOCK = 1'b0;
      if (v.stall_at > 0 && k == v.stall_at + 2) hold_ok = RE && (ABUS == v.src);
      if (v.abort_word > 0 && RE && rd_q.size() == v.abort_word - 1) ABORT = 1'b1;
    end
    INTACK = 1'b0;
    chk({tag, " latency"}, lat, v.exp_lat);
    @(negedge CLK);
    chk({tag, " reads"}, rd_q.size(), v.exp_nrd);
    chk({tag, " writes"}, wr_a.size(), v.exp_nwr);
    if (v.exp_nrd > 0) chk({tag, " rd0 addr"}, rd_q.size() > 0 ? rd_q[0] : 16'hDEAD, v.exp_rd0);
    if (v.exp_nwr > 0) begin
      chk({tag, " last wr addr"}, wr_a.size() > 0 ? wr_a[wr_a.size()-1] : 16'hDEAD, v.exp_wr_a);
      chk({tag, " last wr data"}, wr_d.size() > 0 ? wr_d[wr_d.size()-1] : 16'hDEAD, v.exp_wr_d);
    end
    chk({tag, " mem check"}, mem[v.chk_a[15:1]], v.chk_d);
    if (v.stall_at > 0) chk({tag, " lock hold"}, hold_ok, 1'b1);
    chk({tag, " done low"}, DONE, 1'b0);
    chk({tag, " busy low"}, BUSY, 1'b0);
    chk({tag, " intr set"}, INTR, 1'b1);
    INTACK = 1'b1;
    @(negedge CLK);
    INTACK = 1'b0;
    chk({tag, " intr cleared"}, INTR, 1'b0);
  endtask

  vec_t vecs[8];
  vec_t vr;

  initial begin
    RSTN = 1'b0; LOCK = 1'b1; START = 1'b0; FILL = 1'b0; ABORT = 1'b0; INTACK = 1'b0;
    SRC = '0; DST = '0; LEN = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'h0100 >> 1] = 16'h1111;
    mem[16'h0102 >> 1] = 16'h2222;
    mem[16'h0104 >> 1] = 16'h3333;
    mem[16'h0106 >> 1] = 16'h4444;
    mem[16'h0108 >> 1] = 16'h5555;

    //          src      dst      len   fill abt rst ack stl nrd nwr lat rd0      wr_a     wr_d     chk_a    chk_d
    vecs[0] = '{16'h0100, 16'h0200, 16'd3, 1'b0, 0, 1'b0, 1'b0, 0, 3, 3, 7, 16'h0100, 16'h0204, 16'h3333, 16'h0202, 16'h2222};
    vecs[1] = '{16'h0100, 16'h0400, 16'd0, 1'b0, 0, 1'b0, 1'b1, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0000};
    vecs[2] = '{16'h0100, 16'h0600, 16'd5, 1'b0, 2, 1'b0, 1'b0, 0, 2, 2, 5, 16'h0100, 16'h0602, 16'h2222, 16'h0604, 16'h0000};
    vecs[3] = '{16'h0100, 16'hFFFE, 16'd2, 1'b0, 0, 1'b1, 1'b0, 0, 2, 2, 5, 16'h0100, 16'h0000, 16'h2222, 16'hFFFE, 16'h1111};
    vecs[4] = '{16'hFFFE, 16'h0700, 16'd2, 1'b0, 0, 1'b0, 1'b0, 0, 2, 2, 5, 16'hFFFE, 16'h0702, 16'h2222, 16'h0700, 16'h1111};
    vecs[5] = '{16'h0100, 16'h0800, 16'd4, 1'b0, 1, 1'b0, 1'b0, 0, 1, 1, 3, 16'h0100, 16'h0800, 16'h1111, 16'h0802, 16'h0000};
    vecs[6] = '{16'h0100, 16'h0A00, 16'd1, 1'b0, 0, 1'b0, 1'b0, 1, 1, 1, 6, 16'h0100, 16'h0A00, 16'h1111, 16'h0A00, 16'h1111};
`ifdef DMA_FILL_EN
    vecs[7] = '{16'h00AB, 16'h0300, 16'd4, 1'b1, 0, 1'b0, 1'b0, 0, 0, 4, 5, 16'h0000, 16'h0306, 16'h00AB, 16'h0300, 16'h00AB};
`else
    vecs[7] = '{16'h0100, 16'h0300, 16'd4, 1'b1, 0, 1'b0, 1'b0, 0, 4, 4, 9, 16'h0100, 16'h0306, 16'h4444, 16'h0300, 16'h1111};
`endif

    #12;
    chk("reset BUSY", BUSY, 1'b0);
    chk("reset DONE", DONE, 1'b0);
    chk("reset INTR", INTR, 1'b0);
    chk("reset RE", RE, 1'b0);
    chk("reset WE", WE, 1'b0);
    chk("reset ABUS", ABUS, 16'h0000);
    chk("reset WBUS", WBUS, 16'h0000);
    @(negedge CLK);
    RSTN = 1'b1;

    for (int i = 0; i < 8; i++) run_xfer($sformatf("vec%0d", i), vecs[i]);

    // asynchronous reset while the first word's write is on the bus
    @(negedge CLK);
    START = 1'b1; SRC = 16'h0100; DST = 16'h0900; LEN = 16'd3; FILL = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("pre-reset WE", WE, 1'b1);
    #2 RSTN = 1'b0;
    #1;
    chk("async reset WE", WE, 1'b0);
    chk("async reset BUSY", BUSY, 1'b0);
    chk("async reset ABUS", ABUS, 16'h0000);
    @(negedge CLK);
    RSTN = 1'b1;
    chk("lost write", mem[16'h0900 >> 1], 16'h0000);
    chk("reset INTR", INTR, 1'b0);
    vr = '{16'h0102, 16'h0900, 16'd2, 1'b0, 0, 1'b0, 1'b0, 0, 2, 2, 5, 16'h0102, 16'h0902, 16'h3333, 16'h0900, 16'h2222};
    run_xfer("post-reset", vr);

    chk("RE/WE overlap", overlap, 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
